// File: rtl/blake2_m_select.sv
// rtl/blake2_m_select.sv - BLAKE2b message word scheduler (sigma walk, two words per G instance).
// Optional BLAKE2_M_SELECT_ZEROIZE_EN: clear the stored block on the edge that produces done.
module blake2_m_select #(
    parameter int NUM_ROUNDS = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [1023:0] m,
    input  logic          next,
    output logic [63:0]   G0_m0,
    output logic [63:0]   G0_m1,
    output logic [63:0]   G1_m0,
    output logic [63:0]   G1_m1,
    output logic [63:0]   G2_m0,
    output logic [63:0]   G2_m1,
    output logic [63:0]   G3_m0,
    output logic [63:0]   G3_m1,
    output logic [3:0]    round,
    output logic          half,
    output logic          valid,
    output logic          done
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] words     [16];
    logic [63:0] words_nxt [16];
    logic [3:0]  round_nxt;
    logic        half_nxt;
    logic        done_nxt;
    logic        last_step;
    logic [3:0]  row_sel;
    logic [63:0] row_bits;
    logic [63:0] sel       [8];

    assign valid     = (state == ACTIVE);
    assign last_step = (round == LAST_ROUND) && half;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            round <= 4'd0;
            half  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                words[i] <= 64'd0;
            end
        end else begin
            state <= state_nxt;
            round <= round_nxt;
            half  <= half_nxt;
            done  <= done_nxt;
            for (int i = 0; i < 16; i++) begin
                words[i] <= words_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        half_nxt  = half;
        done_nxt  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            words_nxt[i] = words[i];
        end
        // load outranks next so a restart never advances into the new block
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                words_nxt[i] = m[1023 - 64*i -: 64];
            end
            state_nxt = ACTIVE;
            round_nxt = 4'd0;
            half_nxt  = 1'b0;
        end else if (next && (state == ACTIVE)) begin
            if (last_step) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
`ifdef BLAKE2_M_SELECT_ZEROIZE_EN
                for (int i = 0; i < 16; i++) begin
                    words_nxt[i] = 64'd0;
                end
`endif
            end else if (!half) begin
                half_nxt = 1'b1;
            end else begin
                round_nxt = round + 4'd1;
                half_nxt  = 1'b0;
            end
        end
    end

    // Rounds 10..14 wrap back onto sigma rows 0..4
    assign row_sel = (round >= 4'd10) ? (round - 4'd10) : round;

    always_comb begin
        case (row_sel)
            4'd0:    row_bits = 64'h0123456789ABCDEF;
            4'd1:    row_bits = 64'hEA489FD61C02B753;
            4'd2:    row_bits = 64'hB8C052FDAE367194;
            4'd3:    row_bits = 64'h7931DCBE265A40F8;
            4'd4:    row_bits = 64'h905724AFE1BC683D;
            4'd5:    row_bits = 64'h2C6A0B834D75FE19;
            4'd6:    row_bits = 64'hC51FED4A0763928B;
            4'd7:    row_bits = 64'hDB7EC13950F4862A;
            4'd8:    row_bits = 64'h6FE9B308C2D714A5;
            4'd9:    row_bits = 64'hA2847615FB9E3CD0;
            default: row_bits = 64'h0123456789ABCDEF;
        endcase
    end

    // Row entry p sits in nibble p counted from the MSB; half selects entries 8..15
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            sel[j] = words[4'(row_bits >> (7'd60 - {1'b0, half, 3'(j), 2'b00}))];
        end
    end

    assign G0_m0 = sel[0];
    assign G0_m1 = sel[1];
    assign G1_m0 = sel[2];
    assign G1_m1 = sel[3];
    assign G2_m0 = sel[4];
    assign G2_m1 = sel[5];
    assign G3_m0 = sel[6];
    assign G3_m1 = sel[7];

endmodule

// File: tb/tb_blake2_m_select.sv
// tb/tb_blake2_m_select.sv - scoreboard bench for blake2_m_select.
module tb_blake2_m_select;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic          next = 1'b0;
    logic [1023:0] m = '0;
    logic [63:0]   G0_m0, G0_m1, G1_m0, G1_m1, G2_m0, G2_m1, G3_m0, G3_m1;
    logic [3:0]    round;
    logic          half, valid, done;

    int checks = 0;
    int errors = 0;

    logic [518:0] sb [$];
    logic [518:0] e;

    logic [63:0] mw [16];
    int mr, mh, mv, md;

    int sigma_tb [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    blake2_m_select #(.NUM_ROUNDS(12)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .m(m), .next(next),
        .G0_m0(G0_m0), .G0_m1(G0_m1), .G1_m0(G1_m0), .G1_m1(G1_m1),
        .G2_m0(G2_m0), .G2_m1(G2_m1), .G3_m0(G3_m0), .G3_m1(G3_m1),
        .round(round), .half(half), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [518:0] obs();
        return {round, half, valid, done, G0_m0, G0_m1, G1_m0, G1_m1,
                G2_m0, G2_m1, G3_m0, G3_m1};
    endfunction

    function automatic logic [518:0] exp_vec();
        logic [511:0] g;
        int row, base;
        row  = mr % 10;
        base = (mh != 0) ? 8 : 0;
        for (int k = 0; k < 8; k++) begin
            g[511 - 64*k -: 64] = mw[sigma_tb[row][base + k]];
        end
        return {4'(mr), 1'(mh), 1'(mv), 1'(md), g};
    endfunction

    function automatic logic [1023:0] index_block();
        logic [1023:0] b;
        for (int i = 0; i < 16; i++) b[1023 - 64*i -: 64] = 64'(i);
        return b;
    endfunction

    function automatic logic [1023:0] rand_block();
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) b[1023 - 32*i -: 32] = $urandom;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mw[i] = 64'd0;
        mr = 0; mh = 0; mv = 0; md = 0;
    endtask

    task automatic model_step(input logic ld, input logic nx, input logic [1023:0] blk);
        if (ld) begin
            for (int i = 0; i < 16; i++) mw[i] = blk[1023 - 64*i -: 64];
            mr = 0; mh = 0; mv = 1; md = 0;
        end else if (nx && mv == 1) begin
            md = 0;
            if (mr == 11 && mh == 1) begin
                mv = 0; md = 1;
`ifdef BLAKE2_M_SELECT_ZEROIZE_EN
                for (int i = 0; i < 16; i++) mw[i] = 64'd0;
`endif
            end else if (mh == 0) begin
                mh = 1;
            end else begin
                mr = mr + 1; mh = 0;
            end
        end else begin
            md = 0;
        end
    endtask

    task automatic drive(input logic ld, input logic nx, input logic [1023:0] blk);
        load = ld; next = nx; m = blk;
        if (reset_n) model_step(ld, nx, blk);
        else model_reset();
        sb.push_back(exp_vec());
        @(posedge clk);
        #1;
        load = 1'b0; next = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        sb.push_back(exp_vec());
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL reset_state got %h want %h", obs(), e); end
        checks++;
        if (valid !== 1'b0 || done !== 1'b0 || round !== 4'd0) begin
            errors++; $display("FAIL reset_flags got v=%b d=%b r=%0d want 0 0 0", valid, done, round);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_next_idle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, rand_block());
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL next_idle %0d got %h want %h", i, obs(), e); end
        end
        checks++;
        if (G0_m0 !== 64'd0 || G3_m1 !== 64'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL next_idle_zero got g0=%h g3=%h v=%b want 0 0 0", G0_m0, G3_m1, valid);
        end
    endtask

    task automatic test_walk();
        logic [1023:0] blk;
        blk = index_block();
        drive(1'b1, 1'b0, blk);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL walk_load got %h want %h", obs(), e); end
        checks++;
        if (G0_m0 !== 64'd0 || G0_m1 !== 64'd1 || G1_m0 !== 64'd2 || G1_m1 !== 64'd3 ||
            G2_m0 !== 64'd4 || G2_m1 !== 64'd5 || G3_m0 !== 64'd6 || G3_m1 !== 64'd7 || valid !== 1'b1) begin
            errors++; $display("FAIL walk_r0_col got %h want words 0..7 valid", obs());
        end
        for (int s = 1; s <= 24; s++) begin
            drive(1'b0, 1'b1, blk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL walk_step %0d got %h want %h", s, obs(), e); end
            if (s == 1) begin
                checks++;
                if (G0_m0 !== 64'd8 || G0_m1 !== 64'd9 || G3_m0 !== 64'd14 || G3_m1 !== 64'd15 || half !== 1'b1)
                    begin errors++; $display("FAIL walk_r0_diag got %h want G0=8,9 G3=14,15 half=1", obs()); end
            end
            if (s == 2) begin
                checks++;
                if (round !== 4'd1 || half !== 1'b0 || G0_m0 !== 64'd14 || G0_m1 !== 64'd10 ||
                    G1_m0 !== 64'd4 || G1_m1 !== 64'd8 || G2_m0 !== 64'd9 || G2_m1 !== 64'd15 ||
                    G3_m0 !== 64'd13 || G3_m1 !== 64'd6)
                    begin errors++; $display("FAIL walk_r1_col got %h want r1 14,10,4,8,9,15,13,6", obs()); end
            end
            if (s == 20) begin
                checks++;
                if (round !== 4'd10 || half !== 1'b0 || G0_m0 !== 64'd0 || G0_m1 !== 64'd1)
                    begin errors++; $display("FAIL walk_r10 got r=%0d g0=%h,%h want r=10 0,1", round, G0_m0, G0_m1); end
            end
            if (s == 22) begin
                checks++;
                if (round !== 4'd11 || half !== 1'b0 || G0_m0 !== 64'd14 || G0_m1 !== 64'd10)
                    begin errors++; $display("FAIL walk_r11 got r=%0d g0=%h,%h want r=11 14,10", round, G0_m0, G0_m1); end
            end
            if (s == 23) begin
                checks++;
                if (round !== 4'd11 || half !== 1'b1 || valid !== 1'b1 || G0_m0 !== 64'd1 || G0_m1 !== 64'd12)
                    begin errors++; $display("FAIL walk_last got r=%0d h=%b v=%b want r=11 h=1 v=1", round, half, valid); end
            end
            if (s == 24) begin
                checks++;
                if (done !== 1'b1 || valid !== 1'b0 || round !== 4'd11 || half !== 1'b1)
                    begin errors++; $display("FAIL walk_done got d=%b v=%b r=%0d h=%b want 1 0 11 1", done, valid, round, half); end
                checks++;
`ifdef BLAKE2_M_SELECT_ZEROIZE_EN
                if (G0_m0 !== 64'd0 || G0_m1 !== 64'd0 || G3_m1 !== 64'd0)
                    begin errors++; $display("FAIL walk_zeroize got g0=%h g3m1=%h want 0", G0_m0, G3_m1); end
`else
                if (G0_m0 !== 64'd1 || G0_m1 !== 64'd12)
                    begin errors++; $display("FAIL walk_retain got g0=%h,%h want 1,12", G0_m0, G0_m1); end
`endif
            end
        end
        drive(1'b0, 1'b0, blk);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL walk_done_drop got %h want %h", obs(), e); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL walk_done_width got d=%b want 0", done); end
        drive(1'b0, 1'b1, blk);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL walk_post_next got %h want %h", obs(), e); end
    endtask

    task automatic test_priority();
        logic [1023:0] a, b;
        a = rand_block();
        b = rand_block();
        drive(1'b1, 1'b0, a);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL prio_load got %h want %h", obs(), e); end
        for (int s = 0; s < 6; s++) begin
            drive(1'b0, 1'b1, a);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL prio_step %0d got %h want %h", s, obs(), e); end
        end
        drive(1'b1, 1'b1, b);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL prio_restart got %h want %h", obs(), e); end
        checks++;
        if (round !== 4'd0 || half !== 1'b0 || G0_m0 !== b[1023 -: 64] || G3_m1 !== b[1023 - 448 -: 64])
            begin errors++; $display("FAIL prio_newblk got r=%0d h=%b g0=%h want r=0 h=0 g0=%h", round, half, G0_m0, b[1023 -: 64]); end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 6; s++) begin
            drive((s < 2) ? 1'b1 : 1'b0, (s >= 2) ? 1'b1 : 1'b0, rand_block());
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL b2b_step %0d got %h want %h", s, obs(), e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] a;
        a = rand_block();
        drive(1'b1, 1'b0, a);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rmid_load got %h want %h", obs(), e); end
        for (int s = 0; s < 11; s++) begin
            drive(1'b0, 1'b1, a);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL rmid_step %0d got %h want %h", s, obs(), e); end
        end
        checks++;
        if (round !== 4'd5 || half !== 1'b1)
            begin errors++; $display("FAIL rmid_pos got r=%0d h=%b want 5 1", round, half); end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        sb.push_back(exp_vec());
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rmid_async got %h want %h", obs(), e); end
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, 1'b1, a);
            e = sb.pop_front(); checks++;
            if (obs() !== e || done !== 1'b0) begin errors++; $display("FAIL rmid_held %0d got %h want %h", s, obs(), e); end
        end
        #2 reset_n = 1'b1;
        a = rand_block();
        drive(1'b1, 1'b0, a);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rmid_reload got %h want %h", obs(), e); end
        drive(1'b0, 1'b1, a);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL rmid_reload_next got %h want %h", obs(), e); end
    endtask

    initial begin
        test_reset();
        test_next_idle();
        test_walk();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
